// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply feeder.
// Flat-bus offset helpers locate row, column and C elements inside the packed matrices.
package matmul_pkg;

  localparam int unsigned WORD_WIDTH    = 32;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_RES,
    GAP,
    DONE
  } feeder_state_e;

  // A[i][k] inside the flat A bus
  function automatic int unsigned row_elem_off(int unsigned i, int unsigned k, int unsigned n);
    return WORD_WIDTH * (i * n + k);
  endfunction

  // B[k][j] inside the flat B bus
  function automatic int unsigned col_elem_off(int unsigned k, int unsigned j, int unsigned n);
    return WORD_WIDTH * (k * n + j);
  endfunction

  // C[i][j] inside the flat C bus
  function automatic int unsigned c_elem_off(int unsigned i, int unsigned j, int unsigned n);
    return WORD_WIDTH * (i * n + j);
  endfunction

endpackage

// File: rtl/matmul_feeder_if.sv
// Host and inner-product responder signals of the feeder, grouped for port binding.
// master = feeder side, slave = environment (host, consumer and responder).
interface matmul_feeder_if #(
  parameter int unsigned N = 4
);
  import matmul_pkg::*;

  localparam int unsigned MAT_W = WORD_WIDTH * N * N;
  localparam int unsigned VEC_W = WORD_WIDTH * N;

  logic [MAT_W-1:0]      a_mat;
  logic [MAT_W-1:0]      b_mat;
  logic                  in_stb;
  logic                  in_ack;
  logic [MAT_W-1:0]      c_mat;
  logic                  c_stb;
  logic                  c_ack;
  logic [VEC_W-1:0]      ip_row;
  logic [VEC_W-1:0]      ip_column;
  logic                  ip_row_stb;
  logic                  ip_column_stb;
  logic                  ip_out_ack;
  logic                  ip_row_ack;
  logic                  ip_column_ack;
  logic [WORD_WIDTH-1:0] ip_out;
  logic                  ip_out_stb;
  logic                  err;

  modport master (
    input  a_mat, b_mat, in_stb, c_ack, ip_row_ack, ip_column_ack, ip_out, ip_out_stb,
    output in_ack, c_mat, c_stb, ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack, err
  );

  modport slave (
    output a_mat, b_mat, in_stb, c_ack, ip_row_ack, ip_column_ack, ip_out, ip_out_stb,
    input  in_ack, c_mat, c_stb, ip_row, ip_column, ip_row_stb, ip_column_stb, ip_out_ack, err
  );

endinterface

// File: rtl/matmul_slice_select.sv
// Combinational extraction of row i of A and column j of B from flat matrix buses.
module matmul_slice_select
  import matmul_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [WORD_WIDTH*N*N-1:0] a_src_i,
  input  logic [WORD_WIDTH*N*N-1:0] b_src_i,
  input  logic [$clog2(N)-1:0]      row_idx_i,
  input  logic [$clog2(N)-1:0]      col_idx_i,
  output logic [WORD_WIDTH*N-1:0]   row_c_o,
  output logic [WORD_WIDTH*N-1:0]   col_c_o
);

  localparam int unsigned MIDX_W = $clog2(WORD_WIDTH * N * N);
  localparam int unsigned VIDX_W = $clog2(WORD_WIDTH * N);

  always_comb begin
    row_c_o = '0;
    col_c_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      row_c_o[VIDX_W'(WORD_WIDTH * k) +: WORD_WIDTH] =
        a_src_i[MIDX_W'(row_elem_off(32'(row_idx_i), k, N)) +: WORD_WIDTH];
      col_c_o[VIDX_W'(WORD_WIDTH * k) +: WORD_WIDTH] =
        b_src_i[MIDX_W'(col_elem_off(k, 32'(col_idx_i), N)) +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/matmul_feeder.sv
// Top-level matrix-multiply sequencer: feeds every (row i, column j) pair to one inner-product
// responder in row-major order and assembles C. Optional watchdog: FEEDER_TIMEOUT_EN.
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  matmul_feeder_if.master bus
);

  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned MAT_W  = WORD_WIDTH * N * N;
  localparam int unsigned VEC_W  = WORD_WIDTH * N;
  localparam int unsigned MIDX_W = $clog2(MAT_W);

  feeder_state_e    state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [IDX_W-1:0] iss_i_c, iss_j_c;
  logic [MAT_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [MAT_W-1:0] a_src_c, b_src_c;
  logic [VEC_W-1:0] row_q, row_d, col_q, col_d, sel_row_c, sel_col_c;
  logic             in_ack_q, in_ack_d, c_stb_q, c_stb_d;
  logic             row_stb_q, row_stb_d, col_stb_q, col_stb_d, out_ack_q, out_ack_d;
  logic             last_c, resp_idle_c;
`ifdef FEEDER_TIMEOUT_EN
  logic [15:0]      wdog_q, wdog_d;
  logic             err_q, err_d;
`endif

  // In IDLE the vectors for (0,0) come straight from the input buses being latched
  assign a_src_c = (state_q == IDLE) ? bus.a_mat : a_q;
  assign b_src_c = (state_q == IDLE) ? bus.b_mat : b_q;

  assign last_c      = (i_q == IDX_W'(N - 1)) && (j_q == IDX_W'(N - 1));
  assign resp_idle_c = !bus.ip_out_stb && !bus.ip_row_ack && !bus.ip_column_ack;

  // Indices of the element to issue next (row-major successor of the current one)
  always_comb begin
    iss_i_c = '0;
    iss_j_c = '0;
    if (state_q != IDLE) begin
      if (j_q == IDX_W'(N - 1)) begin
        iss_j_c = '0;
        iss_i_c = (i_q == IDX_W'(N - 1)) ? '0 : i_q + 1'b1;
      end else begin
        iss_i_c = i_q;
        iss_j_c = j_q + 1'b1;
      end
    end
  end

  matmul_slice_select #(.N(N)) u_slice_select (
    .a_src_i   (a_src_c),
    .b_src_i   (b_src_c),
    .row_idx_i (iss_i_c),
    .col_idx_i (iss_j_c),
    .row_c_o   (sel_row_c),
    .col_c_o   (sel_col_c)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    row_d     = row_q;
    col_d     = col_q;
    in_ack_d  = 1'b0;
    c_stb_d   = c_stb_q;
    row_stb_d = row_stb_q;
    col_stb_d = col_stb_q;
    out_ack_d = out_ack_q;
`ifdef FEEDER_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_stb) begin
          a_d       = bus.a_mat;
          b_d       = bus.b_mat;
          in_ack_d  = 1'b1;
          i_d       = '0;
          j_d       = '0;
          row_d     = sel_row_c;
          col_d     = sel_col_c;
          row_stb_d = 1'b1;
          col_stb_d = 1'b1;
          out_ack_d = 1'b1;
          state_d   = ISSUE;
`ifdef FEEDER_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.ip_row_ack && bus.ip_column_ack) begin
          row_stb_d = 1'b0;
          col_stb_d = 1'b0;
          state_d   = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (bus.ip_out_stb) begin
          c_d[MIDX_W'(c_elem_off(32'(i_q), 32'(j_q), N)) +: WORD_WIDTH] = bus.ip_out;
          out_ack_d = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        // Responder must be fully back in idle before the next issue
        if (resp_idle_c) begin
          i_d = iss_i_c;
          j_d = iss_j_c;
          if (last_c) begin
            c_stb_d = 1'b1;
            state_d = DONE;
          end else begin
            row_d     = sel_row_c;
            col_d     = sel_col_c;
            row_stb_d = 1'b1;
            col_stb_d = 1'b1;
            out_ack_d = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      DONE: begin
        if (bus.c_ack) begin
          c_stb_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FEEDER_TIMEOUT_EN
    // Watchdog abort: hand over partial C and flag the stalled responder
    if ((state_q == WAIT_ACK || state_q == WAIT_RES) && wdog_q == TIMEOUT_LIMIT) begin
      row_stb_d = 1'b0;
      col_stb_d = 1'b0;
      out_ack_d = 1'b0;
      err_d     = 1'b1;
      c_stb_d   = 1'b1;
      state_d   = DONE;
    end
    if (state_d != state_q)
      wdog_d = '0;
    else if (state_q == WAIT_ACK || state_q == WAIT_RES)
      wdog_d = wdog_q + 16'd1;
    else
      wdog_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      in_ack_q  <= 1'b0;
      c_stb_q   <= 1'b0;
      row_stb_q <= 1'b0;
      col_stb_q <= 1'b0;
      out_ack_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      wdog_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      row_q     <= row_d;
      col_q     <= col_d;
      in_ack_q  <= in_ack_d;
      c_stb_q   <= c_stb_d;
      row_stb_q <= row_stb_d;
      col_stb_q <= col_stb_d;
      out_ack_q <= out_ack_d;
`ifdef FEEDER_TIMEOUT_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.in_ack        = in_ack_q;
  assign bus.c_mat         = c_q;
  assign bus.c_stb         = c_stb_q;
  assign bus.ip_row        = row_q;
  assign bus.ip_column     = col_q;
  assign bus.ip_row_stb    = row_stb_q;
  assign bus.ip_column_stb = col_stb_q;
  assign bus.ip_out_ack    = out_ack_q;
`ifdef FEEDER_TIMEOUT_EN
  assign bus.err           = err_q;
`else
  assign bus.err           = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_feeder.sv
// Bench for matmul_feeder: behavioural responder returning the integer dot product of the
// vectors it receives, checked against C computed directly from the random A and B matrices.
module tb_matmul_feeder;
  import matmul_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned MAT_W = WORD_WIDTH * N * N;
  localparam int unsigned VEC_W = WORD_WIDTH * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_feeder_if #(.N(N)) bus ();
  matmul_feeder #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ma [N][N];
  logic [31:0] mb [N][N];
  logic [VEC_W-1:0] q_row [$];
  logic [VEC_W-1:0] q_col [$];
  int rsp_mode   = 0;   // 0 normal, 1 row ack leads column ack, 2 never ack
  int max_dly    = 20;
  int hold_elem  = -1;
  bit rsp_kill   = 1'b0;
  int skew_bad   = 0;
  int in_ack_cnt = 0;
  int ack_base   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dot(input logic [VEC_W-1:0] r, input logic [VEC_W-1:0] c);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + r[32*k +: 32] * c[32*k +: 32];
    return s;
  endfunction

  function automatic logic [31:0] ref_c(input int i, input int j);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + ma[i][k] * mb[k][j];
    return s;
  endfunction

  initial forever begin
    step();
    if (bus.in_ack === 1'b1) in_ack_cnt++;
  end

  // Behavioural inner-product responder
  initial begin
    logic [VEC_W-1:0] r, c;
    int d, elem;
    bus.ip_row_ack = 1'b0; bus.ip_column_ack = 1'b0; bus.ip_out_stb = 1'b0; bus.ip_out = '0;
    forever begin
      step();
      if (!rsp_kill && rsp_mode != 2 && bus.ip_row_stb === 1'b1 && bus.ip_column_stb === 1'b1) begin
        r = bus.ip_row; c = bus.ip_column;
        elem = q_row.size();
        q_row.push_back(r); q_col.push_back(c);
        d = int'($urandom_range(max_dly, 0));
        for (int t = 0; t < d && !rsp_kill; t++) step();
        if (rsp_mode == 1) begin
          bus.ip_row_ack = 1'b1;
          for (int t = 0; t < 5 && !rsp_kill; t++) begin
            step();
            if (!(bus.ip_row_stb === 1'b1 && bus.ip_column_stb === 1'b1)) skew_bad++;
          end
        end
        bus.ip_row_ack = 1'b1; bus.ip_column_ack = 1'b1;
        for (int t = 0; t < 1000 && !rsp_kill && (bus.ip_row_stb || bus.ip_column_stb); t++) step();
        bus.ip_row_ack = 1'b0; bus.ip_column_ack = 1'b0;
        d = (elem == hold_elem) ? 40 : int'($urandom_range(max_dly, 0));
        for (int t = 0; t < d && !rsp_kill; t++) step();
        if (!rsp_kill) begin
          bus.ip_out = dot(r, c); bus.ip_out_stb = 1'b1;
          for (int t = 0; t < 1000 && !rsp_kill && bus.ip_out_ack; t++) step();
        end
        bus.ip_out_stb = 1'b0;
      end
      if (rsp_kill) begin
        bus.ip_row_ack = 1'b0; bus.ip_column_ack = 1'b0; bus.ip_out_stb = 1'b0;
      end
    end
  end

  task automatic start_job(input bit hold);
    bit got;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = $urandom(); mb[i][k] = $urandom();
        bus.a_mat[32*(i*N+k) +: 32] = ma[i][k];
        bus.b_mat[32*(i*N+k) +: 32] = mb[i][k];
      end
    q_row.delete(); q_col.delete();
    ack_base = in_ack_cnt;
    bus.in_stb = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      step();
      if (bus.in_ack === 1'b1) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL in_ack_wait: got no in_ack in 50 cycles, required one pulse"); end
    if (!hold) bus.in_stb = 1'b0;
  endtask

  task automatic finish_job(input int cack_dly, input string tag);
    bit got, stable;
    logic [MAT_W-1:0] snap;
    logic [2*VEC_W-1:0] exp_v;
    got = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      if (bus.c_stb === 1'b1) begin got = 1'b1; break; end
      step();
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL %s c_stb_wait: c_stb=0 after 20000 cycles, required 1", tag); return; end
    snap = bus.c_mat; stable = 1'b1;
    for (int t = 0; t < cack_dly; t++) begin
      step();
      if (bus.c_mat !== snap || bus.c_stb !== 1'b1) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL %s c_hold: c_mat/c_stb changed while waiting for c_ack", tag); end
    n_cmp++;
    if (in_ack_cnt - ack_base !== 1) begin
      n_bad++; $display("FAIL %s in_ack_count: got %0d pulses, required 1", tag, in_ack_cnt - ack_base);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        n_cmp++;
        if (bus.c_mat[32*(i*N+j) +: 32] !== ref_c(i, j)) begin
          n_bad++; $display("FAIL %s C[%0d][%0d]: got %h required %h", tag, i, j, bus.c_mat[32*(i*N+j) +: 32], ref_c(i, j));
        end
      end
    n_cmp++;
    if (q_row.size() !== N * N) begin
      n_bad++; $display("FAIL %s issue_count: got %0d issues, required %0d", tag, q_row.size(), N * N);
    end
    for (int e = 0; e < q_row.size() && e < N * N; e++) begin
      for (int k = 0; k < N; k++) begin
        exp_v[VEC_W + 32*k +: 32] = ma[e / N][k];
        exp_v[32*k +: 32]         = mb[k][e % N];
      end
      n_cmp++;
      if ({q_row[e], q_col[e]} !== exp_v) begin
        n_bad++; $display("FAIL %s issue_order[%0d]: got row/col %h required %h", tag, e, {q_row[e], q_col[e]}, exp_v);
      end
    end
    bus.c_ack = 1'b1;
    step();
    bus.c_ack = 1'b0;
    n_cmp++;
    if (bus.c_stb !== 1'b0) begin n_bad++; $display("FAIL %s c_stb_drop: got %b required 0", tag, bus.c_stb); end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.in_ack, bus.c_stb, bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack, bus.err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 000000",
        {bus.in_ack, bus.c_stb, bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack, bus.err});
    end
    n_cmp++;
    if (bus.c_mat !== '0) begin n_bad++; $display("FAIL reset_c_mat: got %h required 0", bus.c_mat); end
    n_cmp++;
    if ({bus.ip_row, bus.ip_column} !== '0) begin n_bad++; $display("FAIL reset_ip_data: got nonzero, required 0"); end
  endtask

  task automatic test_random();
    max_dly = 20;
    for (int r = 0; r < 3; r++) begin
      start_job(1'b0);
      finish_job(int'($urandom_range(5, 0)), "random");
    end
    max_dly = 0;
    start_job(1'b0);
    finish_job(0, "nodelay");
  endtask

  task automatic test_ack_skew();
    rsp_mode = 1; max_dly = 3; skew_bad = 0;
    start_job(1'b0);
    finish_job(0, "skew");
    n_cmp++;
    if (skew_bad !== 0) begin n_bad++; $display("FAIL skew_strobes: strobes low %0d times with one ack, required 0", skew_bad); end
    rsp_mode = 0;
  endtask

  task automatic test_back_to_back();
    bit got;
    max_dly = 4;
    start_job(1'b1);
    finish_job(10, "held");
    q_row.delete(); q_col.delete();
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (bus.in_ack === 1'b1) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL held_rearm: got no in_ack after DONE->IDLE, required one"); end
    bus.in_stb = 1'b0;
    step();
    ack_base = in_ack_cnt - 1;
    finish_job(0, "held2");
  endtask

  task automatic test_reset_mid();
    bit got;
    max_dly = 3; hold_elem = 2 * N + 1;
    start_job(1'b0);
    got = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (q_row.size() >= hold_elem + 1 && bus.ip_row_stb === 1'b0 && bus.ip_out_ack === 1'b1) begin got = 1'b1; break; end
      step();
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL midrst_reach: did not reach WAIT_RES of (2,1)"); end
    rst = 1'b0; rsp_kill = 1'b1;
    step();
    n_cmp++;
    if ({bus.in_ack, bus.c_stb, bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack, bus.err} !== 6'b0) begin
      n_bad++; $display("FAIL midrst_ctrl: got %b required 000000",
        {bus.in_ack, bus.c_stb, bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack, bus.err});
    end
    n_cmp++;
    if ({bus.c_mat, bus.ip_row, bus.ip_column} !== '0) begin n_bad++; $display("FAIL midrst_data: got nonzero, required 0"); end
    step(); step();
    rsp_kill = 1'b0; hold_elem = -1; rst = 1'b1;
    step();
    start_job(1'b0);
    finish_job(0, "restart");
  endtask

  task automatic test_timeout();
    bit seen_c, seen_err;
    rsp_mode = 2;
    start_job(1'b0);
`ifdef FEEDER_TIMEOUT_EN
    seen_c = 1'b0;
    for (int t = 0; t < 70000; t++) begin
      if (bus.c_stb === 1'b1) begin seen_c = 1'b1; break; end
      step();
    end
    n_cmp++;
    if (!seen_c) begin n_bad++; $display("FAIL timeout_done: c_stb=0 after 70000 cycles, required 1"); end
    n_cmp++;
    if ({bus.err, bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack} !== 4'b1000) begin
      n_bad++; $display("FAIL timeout_flags: got %b required 1000", {bus.err, bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack});
    end
    bus.c_ack = 1'b1; step(); bus.c_ack = 1'b0;
    rsp_mode = 0; max_dly = 2;
    start_job(1'b0);
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: err=%b after new in_stb, required 0", bus.err); end
    finish_job(0, "after_timeout");
`else
    seen_c = 1'b0; seen_err = 1'b0;
    for (int t = 0; t < 300; t++) begin
      step();
      if (bus.c_stb !== 1'b0) seen_c = 1'b1;
      if (bus.err !== 1'b0) seen_err = 1'b1;
    end
    n_cmp++;
    if (seen_c) begin n_bad++; $display("FAIL noack_c_stb: c_stb rose without acks, required 0"); end
    n_cmp++;
    if (seen_err) begin n_bad++; $display("FAIL noack_err: err rose, required 0"); end
    n_cmp++;
    if ({bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack} !== 3'b111) begin
      n_bad++; $display("FAIL noack_wait: got strobes %b required 111", {bus.ip_row_stb, bus.ip_column_stb, bus.ip_out_ack});
    end
    rst = 1'b0; step(); rst = 1'b1; rsp_mode = 0; step();
`endif
  endtask

  initial begin
    rst = 1'b0;
    bus.in_stb = 1'b0; bus.c_ack = 1'b0; bus.a_mat = '0; bus.b_mat = '0;
    repeat (3) step();
    test_reset();
    rst = 1'b1;
    step();
    test_random();
    test_ack_skew();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_feeder.md
Name: matmul_feeder

Overview:
- Initiator side of the inner-product stb/ack protocol.
- Accepts two N×N matrices of 32-bit words through an in_stb/in_ack handshake.
- Drives row i of A and column j of B to one inner_product responder for every (i,j), in row-major order, and collects each scalar result into C.
- Presents the full C matrix through a c_stb/c_ack handshake. This is the top-level sequencer of the matrix multiplier.

Parameters:
- N, 4, matrix dimension; number of elements per row/column vector. Legal range 2..8.
- WORD_WIDTH, 32, word width; localparam fixed at 32, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- a_mat  in  32*N*N  matrix A; A[i][k] at bits [32*(i*N+k) +: 32]
- b_mat  in  32*N*N  matrix B; B[k][j] at bits [32*(k*N+j) +: 32]
- in_stb  in  1  A/B valid
- in_ack  out  1  one-cycle pulse when A/B are latched
- c_mat  out  32*N*N  result C; C[i][j] at bits [32*(i*N+j) +: 32]
- c_stb  out  1  C valid
- c_ack  in  1  consumer accepts C
- ip_row  out  32*N  element k at [32*k +: 32]
- ip_column  out  32*N  element k at [32*k +: 32]
- ip_row_stb  out  1  row valid to responder
- ip_column_stb  out  1  column valid to responder
- ip_out_ack  out  1  ready to take the responder result
- ip_row_ack  in  1  responder acknowledges row
- ip_column_ack  in  1  responder acknowledges column
- ip_out  in  32  responder scalar result
- ip_out_stb  in  1  responder result valid
- err  out  1  timeout flag; tied 0 unless FEEDER_TIMEOUT_EN is defined

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; i = 0, j = 0.
  - A/B holding registers and c_mat cleared to 0.
  - All outputs 0, including in_ack, c_stb, all ip_* strobes/acks and err.
- Reset mid-operation aborts immediately. The responder is assumed to share rst.
- Data registers:
  - ip_row and ip_column are registered, loaded from latched A row i and B column j on entry to ISSUE.
  - They are stable until the next ISSUE.
- IDLE:
  - If in_stb: latch a_mat/b_mat, pulse in_ack for one cycle, set i = j = 0, go to ISSUE.
  - in_stb while not in IDLE is ignored (in_ack stays 0).
- ISSUE (1 cycle): assert ip_row_stb, ip_column_stb and ip_out_ack; go to WAIT_ACK.
- WAIT_ACK:
  - Hold all three signals.
  - When ip_row_ack & ip_column_ack are both 1 in the same cycle: drop both strobes next cycle, keep ip_out_ack = 1, go to WAIT_RES.
  - A single ack alone does not advance.
- WAIT_RES:
  - On ip_out_stb = 1: write ip_out to C[i][j], drop ip_out_ack, go to GAP.
  - ip_out_stb seen in any other state is ignored.
- GAP:
  - Wait until ip_out_stb = 0, ip_row_ack = 0 and ip_column_ack = 0, so the responder is back in idle.
  - Then advance the indices: j wraps at N-1 and increments i.
  - If the element just stored was (N-1,N-1), go to DONE; else go to ISSUE.
- DONE:
  - c_stb = 1, c_mat stable.
  - When c_ack = 1: c_stb drops next cycle, go to IDLE.
  - c_ack while c_stb = 0 is ignored.
- Latency and throughput:
  - Driver overhead per element is 3 cycles (ISSUE, acks→WAIT_RES, GAP) plus responder latency.
  - Total = N² × (3 + responder latency) + 2 cycles from in_ack to c_stb.
- Indices: i and j are $clog2(N)-bit counters; they never exceed N-1.
- Data is opaque; the block performs no arithmetic.

Optional Feature:
- FEEDER_TIMEOUT_EN
- Defined:
  - A 16-bit watchdog counts cycles spent in WAIT_ACK or WAIT_RES and clears on each state change.
  - On reaching 16'hFFFF: drop all ip_* signals, set err = 1 (sticky until reset or the next accepted in_stb), go to DONE with partial C.
- Undefined: no counter is generated, err is tied 0, and the block waits indefinitely.

Decomposition:
- Package matmul_pkg:
  - WORD_WIDTH = 32.
  - Feeder state enum (IDLE, ISSUE, WAIT_ACK, WAIT_RES, GAP, DONE).
  - TIMEOUT_LIMIT constant.
  - Functions for the flat-bus offsets of row element, column element and C element.
- Sub-module matmul_slice_select: combinational extraction of row i / column j from the latched A/B buses. The feeder registers its outputs.

Test Plan:
- N=4, A = identity (3F800000 on diagonal, 0 elsewhere), B[k][j] = float(4k+j+1), with the real inner_product attached -> c_stb asserts, C == B bit-exact, in_ack pulses exactly once.
- Behavioural responder that returns 32'h00000000 + 16i + j with random 0–20 cycle delays on acks/out_stb -> C[i][j] == 16i+j for all 16 elements; issue order (0,0),(0,1)…(3,3) checked.
- Responder raises ip_row_ack 5 cycles before ip_column_ack -> strobes stay high until both acks are seen; no element skipped.
- in_stb held high during the whole run and c_ack delayed 10 cycles -> no second in_ack before DONE→IDLE; c_mat stable while c_stb = 1.
- rst low mid-WAIT_RES at element (2,1) -> all outputs 0 next edge; new in_stb restarts at (0,0) and completes correctly.
- FEEDER_TIMEOUT_EN defined, responder never acks -> after 65535 cycles err = 1, c_stb = 1, strobes low; undefined build -> err stays 0 and the block waits.
